// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   N-channel push-button conditioner. Each channel synchronises its raw
//   input, normalises polarity, debounces against a shared timebase tick,
//   and produces press/release pulses, a long-press pulse and optional
//   auto-repeat pulses. One prescaler serves all channels, so the counter
//   widths depend only on tick counts, not on the clock frequency.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous key inputs, one bit per channel
//   key_level    debounced level per channel, 1 = pressed
//   key_press    1-cycle pulse in the first cycle key_level reads 1
//   key_release  1-cycle pulse in the first cycle key_level reads 0
//   key_long     1-cycle pulse when a press has been held LONG_TICKS ticks
//   key_repeat   1-cycle auto-repeat pulse every REPEAT_TICKS ticks after long
//   key_any      OR of key_level
module key_debounce_multi #(
    parameter int N_KEYS         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200,
    parameter int REPEAT_EN      = 1,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_any
);

    localparam int PW = $clog2(TICK_DIV - 1) + 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS - 1) + 1;
    localparam int HW = $clog2(LONG_TICKS - 1) + 1;
    localparam int RW = $clog2(REPEAT_TICKS - 1) + 1;

    // Raw value of a released key; synchroniser flops reset to it so that
    // leaving reset never looks like an edge.
    localparam logic [N_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } hold_state_t;

    logic [PW-1:0]     presc_cnt;
    logic              tick;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] s_norm;

    assign tick = (presc_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // After this XOR, 1 always means "pressed" regardless of board polarity.
    assign s_norm = sync2 ^ RAW_IDLE;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          db_update;
        logic          press_upd;
        logic          rel_upd;

        hold_state_t   state_q;
        hold_state_t   state_d;
        logic [HW-1:0] hold_q;
        logic [HW-1:0] hold_d;
        logic [RW-1:0] rep_q;
        logic [RW-1:0] rep_d;
        logic          long_q;
        logic          long_d;
        logic          repeat_q;
        logic          repeat_d;

        // The level flips on the tick that would take db_cnt past its
        // terminal value; press/release are decoded from that same update so
        // they register in the same cycle as the new level.
        assign db_update = tick && (s_norm[i] != level_q)
                           && (db_cnt == DW'(DEBOUNCE_TICKS - 1));
        assign press_upd = db_update && s_norm[i];
        assign rel_upd   = db_update && !s_norm[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= press_upd;
                release_q <= rel_upd;
                if (s_norm[i] == level_q) begin
                    db_cnt <= '0;
                end else if (db_update) begin
                    level_q <= s_norm[i];
                    db_cnt  <= '0;
                end else if (tick) begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                hold_q   <= '0;
                rep_q    <= '0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                hold_q   <= hold_d;
                rep_q    <= rep_d;
                long_q   <= long_d;
                repeat_q <= repeat_d;
            end
        end

        // Without auto-repeat, hold_q parks at LONG_TICKS (one past its
        // terminal value) so the long-press compare can never match again.
        // A release update overrides everything decided above it, which
        // gives release priority over a coincident long/repeat event.
        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            rep_d    = rep_q;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press_upd) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
                ST_HOLD: begin
                    if (tick && (hold_q != HW'(LONG_TICKS))) begin
                        if (hold_q == HW'(LONG_TICKS - 1)) begin
                            long_d = 1'b1;
                            if (REPEAT_EN != 0) begin
                                state_d = ST_REPEAT;
                                rep_d   = '0;
                            end else begin
                                hold_d = HW'(LONG_TICKS);
                            end
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (tick) begin
                        if (rep_q == RW'(REPEAT_TICKS - 1)) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (rel_upd) begin
                state_d  = ST_IDLE;
                hold_d   = '0;
                rep_d    = '0;
                long_d   = 1'b0;
                repeat_d = 1'b0;
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = repeat_q;
    end

    assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi
//   Directed bench for key_debounce_multi. Instance dut_a uses auto-repeat
//   with active-high keys; instance dut_b has auto-repeat disabled and
//   active-low keys. Both run with TICK_DIV=4, DEBOUNCE_TICKS=3,
//   LONG_TICKS=10, REPEAT_TICKS=4, so a long press fires 40 cycles after
//   the press and repeats follow every 16 cycles.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [3:0] key_level, key_press, key_release, key_long, key_repeat;
    logic       key_any;
    logic [3:0] key_in_b;
    logic [3:0] key_level_b, key_press_b, key_release_b, key_long_b, key_repeat_b;
    logic       key_any_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int press_cnt [4] = '{0, 0, 0, 0};
    int rel_cnt   [4] = '{0, 0, 0, 0};
    int long_cnt  [4] = '{0, 0, 0, 0};
    int rep_cnt   [4] = '{0, 0, 0, 0};
    int press_cyc [4] = '{0, 0, 0, 0};
    int rel_cyc   [4] = '{0, 0, 0, 0};
    int long_cyc  [4] = '{0, 0, 0, 0};
    int rep_q3 [$];
    int any_err  = 0;
    int both_err = 0;
    int lr_err   = 0;

    int pb = 0, rb = 0, lb = 0, repb = 0, other_b = 0;
    int pb_cyc = 0, lb_cyc = 0;

    key_debounce_multi #(
        .N_KEYS(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(10),
        .REPEAT_TICKS(4), .REPEAT_EN(1), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any)
    );

    key_debounce_multi #(
        .N_KEYS(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .LONG_TICKS(10),
        .REPEAT_TICKS(4), .REPEAT_EN(0), .ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .key_in(key_in_b),
        .key_level(key_level_b), .key_press(key_press_b), .key_release(key_release_b),
        .key_long(key_long_b), .key_repeat(key_repeat_b), .key_any(key_any_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: counts pulses per channel and remembers when they came.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) begin
                press_cnt[i] <= press_cnt[i] + 1;
                press_cyc[i] <= cyc;
            end
            if (key_release[i]) begin
                rel_cnt[i] <= rel_cnt[i] + 1;
                rel_cyc[i] <= cyc;
            end
            if (key_long[i]) begin
                long_cnt[i] <= long_cnt[i] + 1;
                long_cyc[i] <= cyc;
            end
            if (key_repeat[i]) rep_cnt[i] <= rep_cnt[i] + 1;
        end
        if (key_repeat[3]) rep_q3.push_back(cyc);
        if (key_any != (|key_level)) any_err <= any_err + 1;
        if ((key_press & key_release) != 4'b0) both_err <= both_err + 1;
        if ((key_long & key_repeat) != 4'b0) lr_err <= lr_err + 1;
        if (key_press_b[0]) begin
            pb     <= pb + 1;
            pb_cyc <= cyc;
        end
        if (key_release_b[0]) rb <= rb + 1;
        if (key_long_b[0]) begin
            lb     <= lb + 1;
            lb_cyc <= cyc;
        end
        if (key_repeat_b != 4'b0) repb <= repb + 1;
        if ((key_press_b[3:1] | key_release_b[3:1]) != 3'b0) other_b <= other_b + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] keys_a, input logic [3:0] keys_b,
                                 input int cycles);
        key_in   = keys_a;
        key_in_b = keys_b;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int lat;
        int p0, r0, l0, p2, r2, l2, p3, r3, l3, q0, n, gap_err, prev;

        rst_n    = 1'b0;
        key_in   = 4'b0001;
        key_in_b = 4'b1111;
        repeat (3) @(negedge clk);
        checkOutput("rst_outs_a", {11'd0, key_level, key_press, key_release,
                    key_long, key_repeat, key_any}, 32'd0);
        checkOutput("rst_outs_b", {11'd0, key_level_b, key_press_b, key_release_b,
                    key_long_b, key_repeat_b, key_any_b}, 32'd0);

        // Leaving reset with key 0 already held: level rises after sync + debounce.
        rst_n = 1'b1;
        lat   = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (key_level[0]) begin
                lat = k;
                break;
            end
        end
        checkOutput("rst_latency_in_10_14", 32'((lat >= 10) && (lat <= 14)), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("rst_press_cnt0", press_cnt[0], 32'd1);
        applyStimulus(4'b0000, 4'b1111, 20);
        checkOutput("rst_rel_cnt0", rel_cnt[0], 32'd1);
        checkOutput("rst_long_cnt0", long_cnt[0], 32'd0);
        checkOutput("b_idle_no_press", pb, 32'd0);

        // Bounce on key 1: 5-cycle pulses never span three ticks.
        p0 = press_cnt[1];
        r0 = rel_cnt[1];
        for (int k = 0; k < 20; k++) begin
            applyStimulus((k % 2 == 0) ? 4'b0010 : 4'b0000, 4'b1111, 5);
        end
        applyStimulus(4'b0000, 4'b1111, 20);
        checkOutput("bounce_press", press_cnt[1] - p0, 32'd0);
        checkOutput("bounce_release", rel_cnt[1] - r0, 32'd0);
        checkOutput("bounce_level", key_level[1], 32'd0);

        // Clean 30-cycle press on key 2.
        p2 = press_cnt[2];
        r2 = rel_cnt[2];
        l2 = long_cnt[2];
        applyStimulus(4'b0100, 4'b1111, 20);
        checkOutput("clean_level_high", key_level[2], 32'd1);
        checkOutput("clean_any_high", key_any, 32'd1);
        applyStimulus(4'b0100, 4'b1111, 10);
        applyStimulus(4'b0000, 4'b1111, 20);
        checkOutput("clean_press", press_cnt[2] - p2, 32'd1);
        checkOutput("clean_release", rel_cnt[2] - r2, 32'd1);
        checkOutput("clean_no_long", long_cnt[2] - l2, 32'd0);
        checkOutput("clean_any_low", key_any, 32'd0);

        // Long press with auto-repeat on key 3.
        p3 = press_cnt[3];
        r3 = rel_cnt[3];
        l3 = long_cnt[3];
        q0 = rep_q3.size();
        applyStimulus(4'b1000, 4'b1111, 120);
        applyStimulus(4'b0000, 4'b1111, 40);
        checkOutput("long_press", press_cnt[3] - p3, 32'd1);
        checkOutput("long_once", long_cnt[3] - l3, 32'd1);
        checkOutput("long_delay_36_44", 32'((long_cyc[3] - press_cyc[3] >= 36)
                    && (long_cyc[3] - press_cyc[3] <= 44)), 32'd1);
        checkOutput("long_release", rel_cnt[3] - r3, 32'd1);
        n = rep_q3.size() - q0;
        checkOutput("repeat_count_4_5", 32'((n >= 4) && (n <= 5)), 32'd1);
        gap_err = 0;
        prev    = long_cyc[3];
        for (int k = q0; k < rep_q3.size(); k++) begin
            if (rep_q3[k] - prev != 16) gap_err++;
            prev = rep_q3[k];
        end
        checkOutput("repeat_gap_16", gap_err, 32'd0);
        checkOutput("no_repeat_after_rel", 32'(prev < rel_cyc[3]), 32'd1);

        // Active-low channel without auto-repeat.
        applyStimulus(4'b0000, 4'b1110, 120);
        checkOutput("b_press", pb, 32'd1);
        checkOutput("b_long", lb, 32'd1);
        checkOutput("b_long_delay_36_44", 32'((lb_cyc - pb_cyc >= 36)
                    && (lb_cyc - pb_cyc <= 44)), 32'd1);
        checkOutput("b_no_repeat", repb, 32'd0);
        applyStimulus(4'b0000, 4'b1111, 30);
        checkOutput("b_release", rb, 32'd1);
        checkOutput("b_other_quiet", other_b, 32'd0);

        // Simultaneous presses on keys 0 and 2, then reset while repeating.
        p0 = press_cnt[0];
        p2 = press_cnt[2];
        l0 = long_cnt[0];
        applyStimulus(4'b0101, 4'b1111, 20);
        checkOutput("sim_press0", press_cnt[0] - p0, 32'd1);
        checkOutput("sim_press2", press_cnt[2] - p2, 32'd1);
        checkOutput("sim_same_cycle", 32'(press_cyc[0] == press_cyc[2]), 32'd1);
        applyStimulus(4'b0101, 4'b1111, 50);
        checkOutput("sim_long0", long_cnt[0] - l0, 32'd1);
        #2;
        rst_n  = 1'b0;
        key_in = 4'b0000;
        #1;
        checkOutput("midrst_outs_a", {11'd0, key_level, key_press, key_release,
                    key_long, key_repeat, key_any}, 32'd0);
        r0 = rel_cnt[0];
        r2 = rel_cnt[2];
        p0 = press_cnt[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("midrst_no_rel0", rel_cnt[0] - r0, 32'd0);
        checkOutput("midrst_no_rel2", rel_cnt[2] - r2, 32'd0);
        checkOutput("midrst_no_press0", press_cnt[0] - p0, 32'd0);

        checkOutput("any_tracks_level", any_err, 32'd0);
        checkOutput("press_rel_exclusive", both_err, 32'd0);
        checkOutput("long_rep_exclusive", lr_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
